// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time instruction loader.
//   loaderState_e : receive FSM states
//   HiResvMask    : bits of a word's high byte that must be zero
//   InstrWidth    : instruction word width
`timescale 1ns/1ps
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StInsLo,
        StInsHi,
        StChk,
        StDone,
        StErr
    } loaderState_e;

    localparam logic [7:0] HiResvMask = 8'hFE;
    localparam int unsigned InstrWidth = 9;

endpackage

// File: rtl/inst_loader.sv
// inst_loader: receives a framed program over a byte stream and writes it into the
// instruction memory from address 0, holding the core in reset until the frame checksum
// verifies.
//
// Ports
//   Clk        in   system clock
//   Reset      in   synchronous active-high reset, returns to IDLE
//   Start      in   pulse; begins reception from IDLE, DONE or ERR
//   InValid    in   InData carries a byte
//   InData     in   stream byte
//   InReady    out  a byte is accepted this cycle if InValid is also high
//   WrEn       out  one-cycle instruction memory write strobe
//   WrAddr     out  write address (word index)
//   WrData     out  9-bit instruction word
//   CoreReset  out  core/PC hold-reset; low only after a successful load
//   Busy       out  frame reception in progress
//   LoadDone   out  frame accepted with good checksum (held until next Start)
//   LoadErr    out  frame rejected (held until next Start)
`timescale 1ns/1ps
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned P = 12
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  InValid,
    input  logic [7:0]            InData,
    output logic                  InReady,
    output logic                  WrEn,
    output logic [P-1:0]          WrAddr,
    output logic [InstrWidth-1:0] WrData,
    output logic                  CoreReset,
    output logic                  Busy,
    output logic                  LoadDone,
    output logic                  LoadErr
);

    // Word counts run 0..2^P, so counters carry one extra bit.
    localparam logic [P:0]  IdxOne   = (P + 1)'(1);
    localparam logic [16:0] MaxWords = 17'(1) << P;

    loaderState_e stateQ, stateD;

    logic [7:0]   accQ;
    logic [7:0]   lenLoQ;
    logic [P:0]   lenQ;
    logic [P:0]   wordIdxQ;
    logic [7:0]   insLoQ;

    logic         wrEnQ;
    logic [P-1:0] wrAddrQ;
    logic [InstrWidth-1:0] wrDataQ;
    logic         coreResetQ;

    logic         receiving;
    logic         accept;
    logic         restart;
    logic         clearAll;
    logic         hiOk;
    logic         wordCommit;
    logic [15:0]  lenFull;
    logic         lenTooBig;

    always_comb begin
        receiving = (stateQ == StLenLo) || (stateQ == StLenHi) || (stateQ == StInsLo) ||
                    (stateQ == StInsHi) || (stateQ == StChk);
        accept     = InValid && receiving;
        restart    = Start && ((stateQ == StDone) || (stateQ == StErr));
        // IDLE keeps everything cleared; a restart from DONE/ERR clears the same way.
        clearAll   = (stateQ == StIdle) || restart;
        hiOk       = (InData & HiResvMask) == 8'h00;
        wordCommit = accept && (stateQ == StInsHi) && hiOk;
        lenFull    = {InData, lenLoQ};
        // Any bit at P or above beyond exactly 2^P is out of range.
        lenTooBig  = {1'b0, lenFull} > MaxWords;
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (Start) stateD = StLenLo;
            end
            StLenLo: begin
                if (accept) stateD = StLenHi;
            end
            StLenHi: begin
                if (accept) begin
                    if (lenTooBig)              stateD = StErr;
                    else if (lenFull == 16'h0)  stateD = StChk;
                    else                        stateD = StInsLo;
                end
            end
            StInsLo: begin
                if (accept) stateD = StInsHi;
            end
            StInsHi: begin
                if (accept) begin
                    if (!hiOk)                               stateD = StErr;
                    else if ((wordIdxQ + IdxOne) == lenQ)    stateD = StChk;
                    else                                     stateD = StInsLo;
                end
            end
            StChk: begin
                if (accept) stateD = (InData == accQ) ? StDone : StErr;
            end
            StDone, StErr: begin
                if (Start) stateD = StLenLo;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // XOR of every frame byte ahead of CHK.
    always_ff @(posedge Clk) begin
        if (Reset || clearAll) begin
            accQ <= 8'h00;
        end else if (accept && (stateQ != StChk)) begin
            accQ <= accQ ^ InData;
        end
    end

    // Length capture and word counter.
    always_ff @(posedge Clk) begin
        if (Reset || clearAll) begin
            lenLoQ   <= 8'h00;
            lenQ     <= '0;
            wordIdxQ <= '0;
        end else if (accept) begin
            if (stateQ == StLenLo) lenLoQ <= InData;
            if ((stateQ == StLenHi) && !lenTooBig) lenQ <= lenFull[P:0];
            if (wordCommit) wordIdxQ <= wordIdxQ + IdxOne;
        end
    end

    // Write register: the word commits on the cycle after its high byte is taken. The
    // address comes from the pre-increment index, so it never wraps at 2^P words.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrEnQ   <= 1'b0;
            wrAddrQ <= '0;
            wrDataQ <= '0;
            insLoQ  <= 8'h00;
        end else begin
            wrEnQ <= wordCommit;
            if (wordCommit) begin
                wrAddrQ <= wordIdxQ[P-1:0];
                wrDataQ <= {InData[0], insLoQ};
            end else if (clearAll) begin
                wrAddrQ <= '0;
            end
            if (accept && (stateQ == StInsLo)) insLoQ <= InData;
        end
    end

    // Core release lags DONE entry by one cycle; a Start in DONE re-asserts it next edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            coreResetQ <= 1'b1;
        end else begin
            coreResetQ <= !((stateQ == StDone) && !Start);
        end
    end

    always_comb begin
        InReady   = receiving;
        Busy      = receiving;
        WrEn      = wrEnQ;
        WrAddr    = wrAddrQ;
        WrData    = wrDataQ;
        CoreReset = coreResetQ;
        LoadDone  = (stateQ == StDone);
        LoadErr   = (stateQ == StErr);
    end

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int P = 12;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         InValid;
    logic [7:0]   InData;
    logic         InReady;
    logic         WrEn;
    logic [P-1:0] WrAddr;
    logic [8:0]   WrData;
    logic         CoreReset;
    logic         Busy;
    logic         LoadDone;
    logic         LoadErr;

    inst_loader #(.P(P)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .InValid   (InValid),
        .InData    (InData),
        .InReady   (InReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .CoreReset (CoreReset),
        .Busy      (Busy),
        .LoadDone  (LoadDone),
        .LoadErr   (LoadErr)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    longint cyc = 0;
    int expAddr[$];
    int expData[$];
    longint wrCycles[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle checker: every write must match the next expected (addr, data).
    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            wrCycles.push_back(cyc);
            if (expAddr.size() == 0) begin
                check("spurious_wren", 32'(WrAddr), 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(WrAddr), 32'(expAddr.pop_front()));
                check("wr_data", 32'(WrData), 32'(expData.pop_front()));
            end
        end
        if (Reset === 1'b0) begin
            check("busy_eq_ready", 32'(Busy), 32'(InReady));
            if (Busy === 1'b1) check("corereset_while_busy", 32'(CoreReset), 32'd1);
        end
    end

    // Frame-level model: outcome 1 = accepted, 2 = rejected; used = bytes the loader takes.
    task automatic modelFrame(input logic [7:0] fr[$], output int outcome, output int used);
        int n;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        n = int'(fr[0]) + 256 * int'(fr[1]);
        x = fr[0] ^ fr[1];
        used = 2;
        if (n > (1 << P)) begin
            outcome = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            lo = fr[used];
            hi = fr[used + 1];
            used += 2;
            if (hi[7:1] != 7'd0) begin
                outcome = 2;
                return;
            end
            x ^= lo ^ hi;
            expAddr.push_back(i);
            expData.push_back(int'({hi[0], lo}));
        end
        used++;
        outcome = (fr[used - 1] == x) ? 1 : 2;
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("start_busy", 32'(Busy), 32'd1);
        check("start_corereset", 32'(CoreReset), 32'd1);
        check("start_done_clr", 32'(LoadDone), 32'd0);
        check("start_err_clr", 32'(LoadErr), 32'd0);
    endtask

    // Offer bytes 0..used-1 with up to gapMax idle cycles before each; noise pulses Start
    // during gaps, which a receiving loader must ignore.
    task automatic sendBytes(input logic [7:0] fr[$], input int used, input int gapMax,
                             input bit noise);
        logic rdy;
        int w;
        for (int k = 0; k < used; k++) begin
            repeat ($urandom_range(0, gapMax)) begin
                InValid = 1'b0;
                Start = noise && ($urandom_range(0, 3) == 0);
                @(posedge Clk); #1;
                Start = 1'b0;
            end
            InValid = 1'b1;
            InData  = fr[k];
            w = 0;
            forever begin
                @(negedge Clk);
                rdy = InReady;
                @(posedge Clk); #1;
                if (rdy) break;
                w++;
                if (w > 20) begin
                    check("ready_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        InValid = 1'b0;
    endtask

    task automatic runFrame(input logic [7:0] fr[$], input int gapMax, input bit noise,
                            output int outcome);
        int used;
        modelFrame(fr, outcome, used);
        pulseStart();
        sendBytes(fr, used, gapMax, noise);
        if (outcome == 1) begin
            check("done_flag", 32'(LoadDone), 32'd1);
            check("done_noerr", 32'(LoadErr), 32'd0);
            check("done_corereset_hold", 32'(CoreReset), 32'd1);
            @(posedge Clk); #1;
            check("done_corereset_fall", 32'(CoreReset), 32'd0);
        end else begin
            check("err_flag", 32'(LoadErr), 32'd1);
            check("err_nodone", 32'(LoadDone), 32'd0);
            check("err_corereset", 32'(CoreReset), 32'd1);
            check("err_ready", 32'(InReady), 32'd0);
        end
        repeat (2) @(posedge Clk);
        #1;
        check("writes_outstanding", 32'(expAddr.size()), 32'd0);
        expAddr.delete();
        expData.delete();
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_inready"}, 32'(InReady), 32'd0);
        check({tag, "_wren"}, 32'(WrEn), 32'd0);
        check({tag, "_wraddr"}, 32'(WrAddr), 32'd0);
        check({tag, "_wrdata"}, 32'(WrData), 32'd0);
        check({tag, "_corereset"}, 32'(CoreReset), 32'd1);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(LoadDone), 32'd0);
        check({tag, "_err"}, 32'(LoadErr), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        int outcome;
        int used;
        int n;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;

        Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        checkResetValues("rst");
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Normal load at full rate.
        fr = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'h00, 8'h59};
        modelFrame(fr, outcome, used);
        check("pin_normal_outcome", 32'(outcome), 32'd1);
        check("pin_normal_used", 32'(used), 32'd7);
        check("pin_normal_w0", 32'(expData[0]), 32'h1A5);
        check("pin_normal_w1", 32'(expData[1]), 32'h0FF);
        expAddr.delete(); expData.delete();
        wrCycles.delete();
        runFrame(fr, 0, 1'b0, outcome);
        check("normal_nwrites", 32'(wrCycles.size()), 32'd2);
        if (wrCycles.size() == 2)
            check("normal_wr_spacing", 32'(wrCycles[1] - wrCycles[0]), 32'd2);

        // Bad checksum: both words still land.
        fr = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'h00, 8'h58};
        wrCycles.delete();
        runFrame(fr, 0, 1'b0, outcome);
        check("badchk_outcome", 32'(outcome), 32'd2);
        check("badchk_nwrites", 32'(wrCycles.size()), 32'd2);

        // Reserved high-byte bit.
        fr = '{8'h01, 8'h00, 8'h10, 8'h03};
        wrCycles.delete();
        runFrame(fr, 0, 1'b0, outcome);
        check("resv_nwrites", 32'(wrCycles.size()), 32'd0);

        // Empty program.
        fr = '{8'h00, 8'h00, 8'h00};
        wrCycles.delete();
        runFrame(fr, 0, 1'b0, outcome);
        check("empty_outcome", 32'(outcome), 32'd1);
        check("empty_nwrites", 32'(wrCycles.size()), 32'd0);

        // Length overflow for P=12.
        fr = '{8'h01, 8'h10};
        modelFrame(fr, outcome, used);
        check("pin_ovf_used", 32'(used), 32'd2);
        runFrame(fr, 0, 1'b0, outcome);
        repeat (3) @(posedge Clk);
        #1;
        check("ovf_ready_stays_low", 32'(InReady), 32'd0);

        // Stall mid-word, then Reset coinciding with the INS_HI byte: that write is dropped.
        fr = '{8'h03, 8'h00, 8'h33};
        pulseStart();
        sendBytes(fr, 3, 4, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        check("stall_busy", 32'(Busy), 32'd1);
        InValid = 1'b1; InData = 8'h01; Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; InValid = 1'b0;
        checkResetValues("abort");
        @(posedge Clk); #1;
        check("abort_wren_after", 32'(WrEn), 32'd0);
        fr = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'h00, 8'h59};
        runFrame(fr, 0, 1'b0, outcome);

        // Randomized frames with gaps, Start noise and occasional corruption.
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            if ($urandom_range(0, 19) == 0) begin
                fr.push_back(8'($urandom_range(0, 255)) | 8'h01);
                fr.push_back(8'($urandom_range(16, 255)));
            end else begin
                n = $urandom_range(0, 6);
                fr.push_back(8'(n));
                fr.push_back(8'h00);
                x = 8'(n);
                for (int i = 0; i < n; i++) begin
                    lo = 8'($urandom_range(0, 255));
                    hi = 8'($urandom_range(0, 1));
                    if ($urandom_range(0, 24) == 0) hi = 8'($urandom_range(2, 255));
                    fr.push_back(lo);
                    fr.push_back(hi);
                    x ^= lo ^ hi;
                end
                if ($urandom_range(0, 5) == 0) x ^= 8'($urandom_range(1, 255));
                fr.push_back(x);
            end
            runFrame(fr, $urandom_range(0, 3), 1'b1, outcome);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
